// File: rtl/fft_pkg.sv
// Shared types and defaults for the fft frame sequencer.
package fft_pkg;

  localparam int unsigned FFT_BIT_WIDTH   = 16;
  localparam int unsigned FFT_N           = 9;
  localparam int unsigned FFT_RD_LAT      = 1;
  localparam int unsigned FFT_TIMEOUT_CYC = 8192;
  localparam int unsigned FFT_POINTS      = 1 << FFT_N;

  // Complex result word: real part in the upper half.
  typedef logic [2*FFT_BIT_WIDTH-1:0] cmplx_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StWait,
    StRdAddr,
    StRdWait,
    StPresent
  } seq_state_t;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sample input stream and bin output stream of the fft frame sequencer.
interface fft_frame_sequencer_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned N         = 9
);
  logic                   s_valid;
  logic [BIT_WIDTH-1:0]   s_data;
  logic                   s_ready;
  logic                   m_valid;
  logic                   m_ready;
  logic [N-1:0]           m_idx;
  logic [2*BIT_WIDTH-1:0] m_data;
  logic                   m_last;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_idx, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_idx, m_data, m_last
  );
endinterface

// File: rtl/fft_bin_out_reg.sv
// Holding register for one result bin with valid/ready handshake and last-bin decode.
// FFT_HALF_SPECTRUM_EN moves the last bin from 2^N-1 to 2^(N-1).
module fft_bin_out_reg
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int unsigned N         = FFT_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [N-1:0]           load_idx,
  input  logic [2*BIT_WIDTH-1:0] load_data,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [N-1:0]           m_idx,
  output logic [2*BIT_WIDTH-1:0] m_data,
  output logic                   m_last
);

`ifdef FFT_HALF_SPECTRUM_EN
  localparam logic [N-1:0] LastBin = {1'b1, {(N-1){1'b0}}};
`else
  localparam logic [N-1:0] LastBin = '1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_idx   <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_idx   <= load_idx;
      m_data  <= load_data;
      m_last  <= (load_idx == LastBin);
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the fft core: loads 2^N samples, launches, waits with a watchdog,
// then streams result bins out. FFT_HALF_SPECTRUM_EN (in fft_bin_out_reg) halves the readout.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = FFT_BIT_WIDTH,
  parameter int unsigned N           = FFT_N,
  parameter int unsigned RD_LAT      = FFT_RD_LAT,
  parameter int unsigned TIMEOUT_CYC = FFT_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  fft_frame_sequencer_if.master  bus,
  output logic                   fft_load,
  output logic [N-1:0]           add_rd,
  output logic [BIT_WIDTH-1:0]   din,
  output logic                   fft_start,
  input  logic                   fft_done,
  input  logic [2*BIT_WIDTH-1:0] dout,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned LatW = $clog2(RD_LAT + 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYC - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT - 1);

  seq_state_t      state_q;
  logic [N-1:0]    idx_q;  // sample count while loading, bin index while reading
  logic [WdW-1:0]  wd_q;
  logic [LatW-1:0] lat_q;
  logic            capture;

  assign bus.s_ready = (state_q == StLoad);
  assign busy        = (state_q != StIdle);
  assign capture     = (state_q == StRdWait) && (lat_q == LatLast);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      wd_q        <= '0;
      lat_q       <= '0;
      fft_load    <= 1'b0;
      add_rd      <= '0;
      din         <= '0;
      fft_start   <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      fft_load  <= 1'b0;
      fft_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          idx_q <= '0;
          if (enable) state_q <= StLoad;
        end
        StLoad: begin
          if (bus.s_valid) begin
            fft_load <= 1'b1;
            add_rd   <= idx_q;
            din      <= bus.s_data;
            idx_q    <= idx_q + 1'b1;
            if (idx_q == '1) state_q <= StLaunch;
          end
        end
        StLaunch: begin
          fft_start <= 1'b1;
          wd_q      <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          // Completion takes priority over a coincident watchdog expiry.
          if (fft_done) begin
            idx_q   <= '0;
            add_rd  <= '0;
            state_q <= StRdAddr;
          end else if (wd_q == WdLast) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StRdAddr: begin
          lat_q   <= '0;
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (capture) state_q <= StPresent;
          else         lat_q   <= lat_q + 1'b1;
        end
        StPresent: begin
          if (bus.m_valid && bus.m_ready) begin
            if (bus.m_last) begin
              frame_cnt <= frame_cnt + 1'b1;
              idx_q     <= '0;
              state_q   <= enable ? StLoad : StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              add_rd  <= idx_q + 1'b1;
              state_q <= StRdAddr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fft_bin_out_reg #(
    .BIT_WIDTH (BIT_WIDTH),
    .N         (N)
  ) u_bin_out (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .load_idx  (idx_q),
    .load_data (dout),
    .m_ready   (bus.m_ready),
    .m_valid   (bus.m_valid),
    .m_idx     (bus.m_idx),
    .m_data    (bus.m_data),
    .m_last    (bus.m_last)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer; bin count follows FFT_HALF_SPECTRUM_EN.
module tb_fft_frame_sequencer;
  import fft_pkg::*;

  localparam int unsigned BW  = 16;
  localparam int unsigned NN  = 9;
  localparam int unsigned RDL = 1;
  localparam int unsigned TMO = 8192;
  localparam int          PTS = 512;
`ifdef FFT_HALF_SPECTRUM_EN
  localparam int BINS = 257;
`else
  localparam int BINS = 512;
`endif

  typedef struct {
    int          gap;
    logic [15:0] salt;
    int          done_delay;
    int          mode;        // 0: m_ready toggles, 1: m_ready held high
    int          exp_frame;
    int          exp_rd_cyc;  // 0: throughput not checked
  } frame_vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            fft_load;
  logic [NN-1:0]   add_rd;
  logic [BW-1:0]   din;
  logic            fft_start;
  logic            fft_done;
  cmplx_t          dout = '0;
  logic            busy;
  logic            timeout_err;
  logic [15:0]     frame_cnt;
  int              n_vec = 0;
  int              n_fail = 0;
  frame_vec_t      vecs [3];

  fft_frame_sequencer_if #(.BIT_WIDTH(BW), .N(NN)) bus ();

  fft_frame_sequencer #(
    .BIT_WIDTH   (BW),
    .N           (NN),
    .RD_LAT      (RDL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .fft_load    (fft_load),
    .add_rd      (add_rd),
    .din         (din),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .dout        (dout),
    .busy        (busy),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic cmplx_t model_word(input int idx);
    return {16'(idx), ~16'(idx)};
  endfunction

  // Core read model: result word appears one cycle after add_rd.
  always @(posedge clk) dout <= model_word(int'(add_rd));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero();
    check("zero_ctl", 64'({bus.s_ready, fft_load, fft_start, bus.m_valid, bus.m_last, busy,
                           timeout_err}), 64'(0));
    check("zero_add_rd", 64'(add_rd), 64'(0));
    check("zero_din", 64'(din), 64'(0));
    check("zero_m_idx", 64'(bus.m_idx), 64'(0));
    check("zero_m_data", 64'(bus.m_data), 64'(0));
    check("zero_frame_cnt", 64'(frame_cnt), 64'(0));
  endtask

  task automatic load_frame(input int gap, input logic [15:0] salt);
    int   exp_idx = 0;
    int   sent = 0;
    int   cyc = 0;
    logic hs = 1'b0;
    while (exp_idx < PTS && cyc < PTS * gap + 64) begin
      @(negedge clk);
      cyc++;
      check("load_strobe", 64'(fft_load), 64'(hs));
      if (hs) begin
        check("load_add_rd", 64'(add_rd), 64'(exp_idx));
        check("load_din", 64'(din), 64'(16'(exp_idx) ^ salt));
        exp_idx++;
      end
      bus.s_valid = (cyc % gap == 0) && (sent < PTS);
      bus.s_data  = 16'(sent) ^ salt;
      hs = bus.s_valid && bus.s_ready;
      if (hs) sent++;
    end
    bus.s_valid = 1'b0;
    check("load_count", 64'(exp_idx), 64'(PTS));
    @(negedge clk);
    check("start_pulse", 64'(fft_start), 64'(1));
    check("load_after_last", 64'(fft_load), 64'(0));
  endtask

  task automatic finish_frame(input int done_delay, input int mode, input int exp_frame,
                              input int exp_rd_cyc);
    int got = 0;
    int rd = 0;
    for (int i = 0; i < done_delay; i++) begin
      @(negedge clk);
      check("wait_no_start", 64'(fft_start), 64'(0));
      check("wait_busy", 64'(busy), 64'(1));
    end
    fft_done = 1'b1;
    while (got < BINS && rd < BINS * 8 + 64) begin
      @(negedge clk);
      fft_done = 1'b0;
      rd++;
      bus.m_ready = (mode == 0) ? rd[0] : 1'b1;
      if (bus.m_valid && bus.m_ready) begin
        check("bin_idx", 64'(bus.m_idx), 64'(got));
        check("bin_data", 64'(bus.m_data), 64'(model_word(got)));
        check("bin_last", 64'(bus.m_last), 64'(got == BINS - 1));
        if (got == BINS - 1 && exp_rd_cyc != 0) check("rd_cycles", 64'(rd), 64'(exp_rd_cyc));
        got++;
      end
    end
    check("bin_count", 64'(got), 64'(BINS));
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("frame_cnt", 64'(frame_cnt), 64'(exp_frame));
    check("valid_after_last", 64'(bus.m_valid), 64'(0));
  endtask

  initial begin
    int wcyc;
    reset       = 1'b0;
    enable      = 1'b1;
    fft_done    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    vecs[0] = '{1, 16'h0000, 100, 0, 1, 0};
    vecs[1] = '{3, 16'hA5A5, 5, 1, 2, int'(RDL + 2) * BINS};
    vecs[2] = '{2, 16'h5A0F, 0, 0, 3, 0};

    repeat (5) begin
      @(negedge clk);
      check_all_zero();
    end
    reset = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", 64'(bus.s_ready), 64'(1));

    for (int i = 0; i < 3; i++) begin
      load_frame(vecs[i].gap, vecs[i].salt);
      finish_frame(vecs[i].done_delay, vecs[i].mode, vecs[i].exp_frame, vecs[i].exp_rd_cyc);
    end

    // Watchdog: no fft_done, enable dropped so the block parks in IDLE.
    enable = 1'b0;
    load_frame(1, 16'h0F0F);
    wcyc = 0;
    while (!timeout_err && wcyc < int'(TMO) + 100) begin
      @(negedge clk);
      wcyc++;
    end
    check("wd_cycles", 64'(wcyc), 64'(TMO));
    check("wd_idle", 64'(busy), 64'(0));
    check("wd_frame_cnt", 64'(frame_cnt), 64'(3));
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("wd_sticky", 64'(timeout_err), 64'(1));
    check("wd_reload", 64'(bus.s_ready), 64'(1));

    // Reset while waiting on the core, then a clean frame from add_rd 0.
    load_frame(2, 16'h3C3C);
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    check_all_zero();
    reset = 1'b1;
    load_frame(1, 16'h0001);
    finish_frame(3, 1, 1, int'(RDL + 2) * BINS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no end of test, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Frame-level controller that sits between the audio sample stream and the fft core. It drives the core's `fft_load`, `add_rd`, `din` and `fft_start` inputs.
- Buffers nothing itself. It counts 2^N samples into the core, launches the transform and waits for `fft_done`, with a watchdog on that wait.
- It then reads the result bins back through `add_rd`/`dout` and presents them on a valid/ready output stream.
- Runs continuously, frame after frame, while `enable` is high.

Parameters:
- BIT_WIDTH, 16, real-sample width; complex word is 2*BIT_WIDTH (real in upper half).
- N, 9, log2 of FFT points (512).
- RD_LAT, 1, cycles from `add_rd` change to valid `dout`.
- TIMEOUT_CYC, 8192, maximum WAIT cycles before declaring a fault.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset: low on a clk rising edge resets the block.
- enable  in  1  permits new frames.
- s_valid  in  1  input sample valid.
- s_data  in  BIT_WIDTH  input sample.
- s_ready  out  1  block accepts a sample.
- fft_load  out  1  core write strobe for one sample.
- add_rd  out  N  core sample/bin index.
- din  out  BIT_WIDTH  sample to core.
- fft_start  out  1  one-cycle launch pulse.
- fft_done  in  1  core completion, level-sampled.
- dout  in  2*BIT_WIDTH  core result word.
- m_valid  out  1  bin valid.
- m_ready  in  1  downstream accepts bin.
- m_idx  out  N  bin index.
- m_data  out  2*BIT_WIDTH  bin value.
- m_last  out  1  final bin of frame.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog fault.
- frame_cnt  out  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset (reset==0 at edge): state IDLE; all outputs 0, including `add_rd`, `din`, `m_data`, `frame_cnt` and `timeout_err`. Reset mid-frame abandons the frame with no partial output.
- States: IDLE, LOAD, LAUNCH, WAIT, RDADDR, RDWAIT, PRESENT.
- IDLE: moves to LOAD when `enable`==1; sample counter cleared.
- LOAD:
  - `s_ready` = 1 (decoded from state only).
  - On `s_valid && s_ready`, next cycle: `fft_load`=1, `add_rd`=count, `din`=`s_data`. All three are registered, so exactly one load cycle per handshake.
  - Gaps in `s_valid` give `fft_load`=0 with `add_rd`/`din` held.
  - The 2^N-th handshake (count == 2^N-1) moves to LAUNCH.
- LAUNCH: `s_ready`=0 and the last `fft_load` occurs this cycle; next cycle `fft_start`=1 for exactly one cycle and the state moves to WAIT.
- WAIT:
  - Watchdog counts from 0.
  - `fft_done`==1 moves to RDADDR with bin counter 0.
  - If the watchdog reaches TIMEOUT_CYC-1 without `fft_done`: set `timeout_err`, go to IDLE, `frame_cnt` unchanged.
  - `fft_done` and timeout in the same cycle: done wins.
- RDADDR: `add_rd` = bin counter, `fft_load`=0; go to RDWAIT.
- RDWAIT: wait RD_LAT cycles; on the last one, capture `dout` into `m_data` and the index into `m_idx`, and go to PRESENT.
- PRESENT:
  - `m_valid`=1; `m_data`/`m_idx`/`m_last` stable until `m_ready`.
  - On `m_valid && m_ready`:
    - Not the last bin: increment the bin counter and go to RDADDR.
    - Last bin: `frame_cnt`+1, then LOAD if `enable`, else IDLE.
  - Throughput is one bin per RD_LAT+2 cycles minimum.
- `enable` is sampled only in IDLE and at frame end; deassertion mid-frame completes the current frame.
- `timeout_err` is cleared only by reset.
- Last bin index is 2^N-1.

Optional Feature:
- FFT_HALF_SPECTRUM_EN.
- Defined: readout stops after bin 2^(N-1), i.e. 257 bins for N=9 (real-input symmetry), with `m_last` on idx 2^(N-1).
- Undefined: all 2^N bins are read, with `m_last` on idx 2^N-1.
- LOAD behaviour is identical in both builds.

Decomposition:
- Shared package `fft_pkg`:
  - state enum `seq_state_t`;
  - `localparam FFT_POINTS = 1<<N`;
  - complex word typedef `cmplx_t` (2*BIT_WIDTH, real upper);
  - default TIMEOUT_CYC.
- One natural sub-module, `fft_bin_out_reg`: the PRESENT holding register with valid/ready handshake and `m_last` decode. Everything else stays inline.

Test Plan:
- Reset/idle: hold reset=0 5 cycles with `enable`=1 -> all outputs 0; after release `s_ready`=1 one cycle later.
- Full frame load:
  - Stimulus: ramp `s_data`=0..511, `s_valid` always 1.
  - Required: 512 `fft_load` pulses with `add_rd`=0..511 and `din`=ramp, each one cycle after its handshake.
  - Required: `fft_start` a single pulse exactly 2 cycles after the 512th handshake.
- Readout with backpressure:
  - Stimulus: `fft_done` 100 cycles after start; model returns `dout`={idx,~idx} one cycle after `add_rd`; `m_ready` toggles 1/0.
  - Required: 512 bins with `m_idx` 0..511 and matching data, `m_last` only at 511, `frame_cnt`=1.
- Gapped input: `s_valid` 1-of-3 cycles -> still exactly 512 loads, `add_rd` contiguous, no duplicate writes.
- Watchdog: `fft_done` held 0 -> `timeout_err`=1 after 8192 WAIT cycles, state IDLE, `frame_cnt` unchanged; stays set until reset.
- Reset mid-operation and half-spectrum:
  - Reset asserted in WAIT -> outputs 0 next cycle, new frame loads from `add_rd`=0.
  - With FFT_HALF_SPECTRUM_EN: 257 bins, `m_last` at idx 256.
